burst_channel_switch: RTL and testbench
=======================================

BURST_CHANNEL_SWITCH -- requirements
Module: burst_channel_switch

Interface
REQ-001 The block SHALL have parameter M, default 2, meaning the number of source ports.
REQ-002 The block SHALL have parameter N, default 2, meaning the number of destination ports.
REQ-003 The block SHALL have parameter WIDTH, default 64, meaning the payload bits per beat.
REQ-004 The block SHALL have parameter LOCK_BURST, default 1: 1 = grant held until the last beat; 0 = re-arbitration every beat.
REQ-005 The block SHALL have derived parameters LOG_N = (N>1 ? clog2(N) : 1) and LOG_M = (M>1 ? clog2(M) : 1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port srcVld_i, input, [M-1:0]: per-source beat valid.
REQ-009 The block SHALL have port srcTarget_i, input, [LOG_N-1:0][M]: per-source destination index.
REQ-010 The block SHALL have port srcDat_i, input, [WIDTH-1:0][M]: per-source payload.
REQ-011 The block SHALL have port srcLast_i, input, [M-1:0]: marks the final beat of a burst.
REQ-012 The block SHALL have port srcRdy_o, output, [M-1:0]: beat accepted when srcVld_i & srcRdy_o.
REQ-013 The block SHALL have port srcDecErr_o, output, [M-1:0]: one-cycle pulse when a beat with target >= N is accepted.
REQ-014 The block SHALL have port dstVld_o, output, [N-1:0]: registered per-destination valid.
REQ-015 The block SHALL have port dstDat_o, output, [WIDTH-1:0][N]: registered payload.
REQ-016 The block SHALL have port dstLast_o, output, [N-1:0]: registered last flag.
REQ-017 The block SHALL have port dstSrc_o, output, [LOG_M-1:0][N]: index of the source that produced the beat.
REQ-018 The block SHALL have port dstRdy_i, input, [N-1:0]: destination ready.

Function
REQ-019 Each destination SHALL have a one-entry output register; a beat accepted at edge k SHALL appear on dstVld_o/dstDat_o/dstLast_o/dstSrc_o after edge k, giving 1-cycle latency.
REQ-020 The output register SHALL be loadable when it is empty or when dstRdy_i is 1 in that cycle, giving full throughput of one beat per cycle per destination.
REQ-021 srcRdy_o[i] SHALL be 1 only when source i is the current winner for its target and that target's register is loadable.
REQ-022 Each destination SHALL run a round-robin arbiter among requesting sources, searching from pointer rr upward modulo M.
REQ-023 After the last beat (or, when LOCK_BURST=0, any beat) of the winner w is accepted, rr SHALL become (w+1) mod M.
REQ-024 Each destination SHALL have a two-state FSM, IDLE/LOCKED, with owner register.
REQ-025 IDLE->LOCKED SHALL occur on acceptance of a beat with srcLast_i=0 when LOCK_BURST=1, with owner := winner.
REQ-026 In LOCKED, only the owner SHALL be granted, with other requests held off; LOCKED->IDLE SHALL occur on acceptance of the owner's beat with srcLast_i=1.
REQ-027 A single-beat burst (last=1) accepted in IDLE SHALL leave the FSM in IDLE.
REQ-028 When LOCK_BURST=0, the FSM SHALL stay IDLE permanently.
REQ-029 A beat with srcTarget_i >= N SHALL be accepted unconditionally (srcRdy_o=1) and dropped, with srcDecErr_o pulsed in the same cycle.
REQ-030 Simultaneous requests to different destinations SHALL proceed in parallel with no cross-destination coupling.
REQ-031 Sources SHALL hold srcTarget_i/srcDat_i stable while srcVld_i=1 and not accepted; the block SHALL not check this.
REQ-032 srcRdy_o SHALL not depend on srcDat_i or srcLast_i; it SHALL depend combinationally on srcVld_i, srcTarget_i, dstRdy_i and state.

Reset
REQ-033 On rst=1 at a clk edge, dstVld_o SHALL be 0, dstLast_o 0, dstDat_o 0, dstSrc_o 0, FSM IDLE, owner 0, rr 0.
REQ-034 During rst, srcRdy_o and srcDecErr_o SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst, with no beat delivered after reset deassertion unless new.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (ST_IDLE, ST_LOCKED) and the clog2-based width helper.
REQ-037 Per-destination logic (arbiter, FSM, output register) SHALL be one sub-module, dst_port_arbiter, instantiated N times in a generate loop.
REQ-038 The top level SHALL only perform request fan-out, target decode and srcRdy_o OR-reduction.

Verification
REQ-039 Scenario: M=2, N=2, both sources send 1-beat bursts to dst0 every cycle with dstRdy_i=1 -> dstSrc_o alternates 0,1,0,1, one beat per cycle.
REQ-040 Scenario: src0 sends a 4-beat burst to dst1 while src1 requests dst1 from cycle 1 -> dst1 receives 4 beats from src0 contiguously, then src1; src1 srcRdy_o stays 0 until src0's last beat is accepted.
REQ-041 Scenario: same as REQ-040 with LOCK_BURST=0 -> beats interleave src0, src1, src0, ...
REQ-042 Scenario: dstRdy_i=0 for 3 cycles with dstVld_o=1 -> dstDat_o held stable, srcRdy_o=0; after release, one beat per cycle.
REQ-043 Scenario: N=3, srcTarget_i=3 -> srcRdy_o=1 and srcDecErr_o=1 for one cycle, with no dstVld_o.
REQ-044 Scenario: rst asserted after beat 2 of a 4-beat burst -> next cycle FSM IDLE, all dstVld_o=0, and a new request from src1 is granted first (rr=0, src0 idle).

Source files
------------

// File: rtl/burst_channel_switch_pkg.sv
// Shared definitions for the burst channel switch: per-destination FSM state
// encoding and the index-width helper used to size source/destination indices.
package burst_channel_switch_pkg;

  typedef logic [0:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE   = 1'b0;
  localparam fsm_state_t ST_LOCKED = 1'b1;

  // Bits needed to index n items; a single item still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_channel_switch_if.sv
// Source and destination handshake bundle for burst_channel_switch.
//   src*  : M source ports (valid, target, payload, last in; ready, decode error out)
//   dst*  : N destination ports (valid, payload, last, source index out; ready in)
// Modport slave is the switch itself; master is whatever drives sources and sinks.
interface burst_channel_switch_if #(
  parameter int unsigned M     = 2,
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 64
);
  import burst_channel_switch_pkg::*;

  localparam int unsigned LOG_N = idx_width(N);
  localparam int unsigned LOG_M = idx_width(M);

  logic [M-1:0]                 srcVld_i;
  logic [M-1:0][LOG_N-1:0]      srcTarget_i;
  logic [M-1:0][WIDTH-1:0]      srcDat_i;
  logic [M-1:0]                 srcLast_i;
  logic [M-1:0]                 srcRdy_o;
  logic [M-1:0]                 srcDecErr_o;
  logic [N-1:0]                 dstVld_o;
  logic [N-1:0][WIDTH-1:0]      dstDat_o;
  logic [N-1:0]                 dstLast_o;
  logic [N-1:0][LOG_M-1:0]      dstSrc_o;
  logic [N-1:0]                 dstRdy_i;

  modport slave (
    input  srcVld_i, srcTarget_i, srcDat_i, srcLast_i, dstRdy_i,
    output srcRdy_o, srcDecErr_o, dstVld_o, dstDat_o, dstLast_o, dstSrc_o
  );

  modport master (
    output srcVld_i, srcTarget_i, srcDat_i, srcLast_i, dstRdy_i,
    input  srcRdy_o, srcDecErr_o, dstVld_o, dstDat_o, dstLast_o, dstSrc_o
  );

endinterface

// File: rtl/dst_port_arbiter.sv
// One destination port: round-robin arbiter over M sources, burst-lock FSM
// (IDLE/LOCKED with owner) and a one-entry output register.
//   req_i      : per-source request already decoded for this destination
//   src_dat_i  : all source payloads; src_last_i : all source last flags
//   grant_o    : one-hot acceptance this cycle (contributes to srcRdy_o)
//   dst_*_o    : registered beat, dst_rdy_i pops it
module dst_port_arbiter
  import burst_channel_switch_pkg::*;
#(
  parameter int unsigned M          = 2,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LOCK_BURST = 1,
  localparam int unsigned LOG_M     = idx_width(M)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [M-1:0]             req_i,
  input  logic                     dst_rdy_i,
  input  logic [M-1:0][WIDTH-1:0]  src_dat_i,
  input  logic [M-1:0]             src_last_i,
  output logic [M-1:0]             grant_o,
  output logic                     dst_vld_o,
  output logic [WIDTH-1:0]         dst_dat_o,
  output logic                     dst_last_o,
  output logic [LOG_M-1:0]         dst_src_o
);

  fsm_state_t       state_q, state_d;
  logic [LOG_M-1:0] owner_q, owner_d;
  logic [LOG_M-1:0] rr_q, rr_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             last_q, last_d;
  logic [LOG_M-1:0] src_q, src_d;

  logic             found;
  logic [LOG_M-1:0] winner;
  logic             loadable;
  logic             accept;
  logic             win_last;
  int unsigned      idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    loadable = !vld_q || dst_rdy_i;
    if (state_q == ST_LOCKED) begin
      // Mid-burst: only the owner may proceed, everyone else waits.
      found  = req_i[owner_q];
      winner = owner_q;
    end else begin
      for (int unsigned k = 0; k < M; k++) begin
        idx = (32'(rr_q) + k) % M;
        if (!found && req_i[LOG_M'(idx)]) begin
          found  = 1'b1;
          winner = LOG_M'(idx);
        end
      end
    end
    accept   = found && loadable;
    win_last = src_last_i[winner];
    grant_o  = '0;
    if (accept) grant_o[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    last_d  = last_q;
    src_d   = src_q;
    if (accept) begin
      vld_d  = 1'b1;
      dat_d  = src_dat_i[winner];
      last_d = win_last;
      src_d  = winner;
    end else if (dst_rdy_i) begin
      vld_d  = 1'b0;
    end
    if (accept && (win_last || LOCK_BURST == 0)) begin
      rr_d = LOG_M'((32'(winner) + 1) % M);
    end
    if (accept && LOCK_BURST != 0) begin
      if (state_q == ST_IDLE && !win_last) begin
        state_d = ST_LOCKED;
        owner_d = winner;
      end else if (state_q == ST_LOCKED && win_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      last_q  <= last_d;
      src_q   <= src_d;
    end
  end

  assign dst_vld_o  = vld_q;
  assign dst_dat_o  = dat_q;
  assign dst_last_o = last_q;
  assign dst_src_o  = src_q;

endmodule

// File: rtl/burst_channel_switch.sv
// M-source by N-destination burst switch. Decodes each source's target into
// per-destination requests, flags out-of-range targets as decode errors (beat
// accepted and dropped), and ORs the per-destination grants into srcRdy_o.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : source/destination handshake bundle (slave side)
module burst_channel_switch
  import burst_channel_switch_pkg::*;
#(
  parameter int unsigned M          = 2,
  parameter int unsigned N          = 2,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LOCK_BURST = 1,
  localparam int unsigned LOG_N     = idx_width(N),
  localparam int unsigned LOG_M     = idx_width(M)
) (
  input logic                  clk,
  input logic                  rst,
  burst_channel_switch_if.slave bus
);

  logic [N-1:0][M-1:0]     req;
  logic [N-1:0][M-1:0]     grant;
  logic [M-1:0]            dec_err;
  logic [M-1:0]            src_rdy;
  logic [N-1:0]            dst_vld;
  logic [N-1:0][WIDTH-1:0] dst_dat;
  logic [N-1:0]            dst_last;
  logic [N-1:0][LOG_M-1:0] dst_src;

  // Requests are masked during reset so nothing is granted or flagged.
  always_comb begin
    req     = '0;
    dec_err = '0;
    for (int unsigned i = 0; i < M; i++) begin
      dec_err[i] = !rst && bus.srcVld_i[i] && (32'(bus.srcTarget_i[i]) >= N);
      for (int unsigned d = 0; d < N; d++) begin
        req[d][i] = !rst && bus.srcVld_i[i] && (32'(bus.srcTarget_i[i]) == d);
      end
    end
  end

  always_comb begin
    src_rdy = '0;
    for (int unsigned i = 0; i < M; i++) begin
      src_rdy[i] = dec_err[i];
      for (int unsigned d = 0; d < N; d++) begin
        src_rdy[i] = src_rdy[i] | grant[d][i];
      end
    end
  end

  for (genvar d = 0; d < N; d++) begin : g_dst
    dst_port_arbiter #(
      .M          (M),
      .WIDTH      (WIDTH),
      .LOCK_BURST (LOCK_BURST)
    ) u_dst_port_arbiter (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req[d]),
      .dst_rdy_i  (bus.dstRdy_i[d]),
      .src_dat_i  (bus.srcDat_i),
      .src_last_i (bus.srcLast_i),
      .grant_o    (grant[d]),
      .dst_vld_o  (dst_vld[d]),
      .dst_dat_o  (dst_dat[d]),
      .dst_last_o (dst_last[d]),
      .dst_src_o  (dst_src[d])
    );
  end

  assign bus.srcRdy_o    = src_rdy;
  assign bus.srcDecErr_o = dec_err;
  assign bus.dstVld_o    = dst_vld;
  assign bus.dstDat_o    = dst_dat;
  assign bus.dstLast_o   = dst_last;
  assign bus.dstSrc_o    = dst_src;

endmodule

// File: tb/tb_burst_channel_switch.sv
// Directed bench for burst_channel_switch: a locked-burst M=2/N=2 instance, an
// unlocked M=2/N=2 instance and an M=2/N=3 instance for decode errors.
module tb_burst_channel_switch;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  burst_channel_switch_if #(.M(2), .N(2), .WIDTH(64)) bus_main ();
  burst_channel_switch_if #(.M(2), .N(2), .WIDTH(64)) bus_nl ();
  burst_channel_switch_if #(.M(2), .N(3), .WIDTH(64)) bus_n3 ();

  burst_channel_switch #(.M(2), .N(2), .WIDTH(64), .LOCK_BURST(1)) u_main (
    .clk (clk), .rst (rst), .bus (bus_main)
  );
  burst_channel_switch #(.M(2), .N(2), .WIDTH(64), .LOCK_BURST(0)) u_nolock (
    .clk (clk), .rst (rst), .bus (bus_nl)
  );
  burst_channel_switch #(.M(2), .N(3), .WIDTH(64), .LOCK_BURST(1)) u_n3 (
    .clk (clk), .rst (rst), .bus (bus_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Locked 4-beat burst from src0 to dst1, src1 joins on cycle 1.
  int s40_v0[5]  = '{1, 1, 1, 1, 0};
  int s40_l0[5]  = '{0, 0, 0, 1, 0};
  int s40_d0[5]  = '{10, 11, 12, 13, 13};
  int s40_v1[5]  = '{0, 1, 1, 1, 1};
  int s40_rdy[5] = '{1, 1, 1, 1, 2};
  int s40_out[5] = '{10, 11, 12, 13, 20};
  int s40_src[5] = '{0, 0, 0, 0, 1};

  // Same traffic shape without locking: beats alternate between sources.
  int s41_v0[5]  = '{1, 1, 1, 1, 1};
  int s41_d0[5]  = '{10, 11, 11, 12, 12};
  int s41_l0[5]  = '{0, 0, 0, 0, 1};
  int s41_v1[5]  = '{0, 1, 1, 1, 0};
  int s41_d1[5]  = '{20, 20, 21, 21, 21};
  int s41_l1[5]  = '{0, 0, 1, 1, 1};
  int s41_rdy[5] = '{1, 2, 1, 2, 1};
  int s41_out[5] = '{10, 20, 11, 21, 12};
  int s41_src[5] = '{0, 1, 0, 1, 0};

  // Backpressure on dst0 for three cycles.
  int s42_dr[6]  = '{1, 0, 0, 0, 1, 1};
  int s42_d0[6]  = '{30, 31, 31, 31, 31, 32};
  int s42_rdy[6] = '{1, 0, 0, 0, 1, 1};
  int s42_out[6] = '{30, 30, 30, 30, 31, 32};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus_main.srcVld_i = '0; bus_main.srcTarget_i = '0; bus_main.srcDat_i = '0;
    bus_main.srcLast_i = '0; bus_main.dstRdy_i = '1;
    bus_nl.srcVld_i = '0; bus_nl.srcTarget_i = '0; bus_nl.srcDat_i = '0;
    bus_nl.srcLast_i = '0; bus_nl.dstRdy_i = '1;
    bus_n3.srcVld_i = '0; bus_n3.srcTarget_i = '0; bus_n3.srcDat_i = '0;
    bus_n3.srcLast_i = '0; bus_n3.dstRdy_i = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();

    // Reset: ready and decode error held low even with valid requests.
    @(negedge clk);
    bus_main.srcVld_i = 2'b11; bus_main.srcLast_i = 2'b11;
    bus_n3.srcVld_i = 2'b01; bus_n3.srcTarget_i[0] = 2'd3;
    #1;
    check_eq("rst_src_rdy", 64'(bus_main.srcRdy_o), 64'h0);
    check_eq("rst_dec_err", 64'(bus_n3.srcDecErr_o), 64'h0);
    @(posedge clk); #1;
    check_eq("rst_dst_vld", 64'(bus_main.dstVld_o), 64'h0);
    check_eq("rst_dst_dat", bus_main.dstDat_o[0], 64'h0);
    check_eq("rst_dst_src", 64'(bus_main.dstSrc_o), 64'h0);
    check_eq("rst_dst_last", 64'(bus_main.dstLast_o), 64'h0);
    do_reset();

    // Two single-beat sources on dst0: round-robin alternation.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_main.srcVld_i = 2'b11; bus_main.srcTarget_i = '0; bus_main.srcLast_i = 2'b11;
      bus_main.srcDat_i[0] = 64'hA0; bus_main.srcDat_i[1] = 64'hB1;
      #1;
      check_eq("rr_src_rdy", 64'(bus_main.srcRdy_o), (c % 2 == 0) ? 64'h1 : 64'h2);
      @(posedge clk); #1;
      check_eq("rr_dst_vld", 64'(bus_main.dstVld_o[0]), 64'h1);
      check_eq("rr_dst_src", 64'(bus_main.dstSrc_o[0]), 64'(c % 2));
      check_eq("rr_dst_dat", bus_main.dstDat_o[0], (c % 2 == 0) ? 64'hA0 : 64'hB1);
    end
    do_reset();

    // Locked burst: src1 held off until src0's last beat.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus_main.srcTarget_i[0] = 1'b1; bus_main.srcTarget_i[1] = 1'b1;
      bus_main.srcVld_i[0] = 1'(s40_v0[c]); bus_main.srcLast_i[0] = 1'(s40_l0[c]);
      bus_main.srcDat_i[0] = 64'(s40_d0[c]);
      bus_main.srcVld_i[1] = 1'(s40_v1[c]); bus_main.srcLast_i[1] = 1'b1;
      bus_main.srcDat_i[1] = 64'd20;
      #1;
      check_eq("lock_src_rdy", 64'(bus_main.srcRdy_o), 64'(s40_rdy[c]));
      @(posedge clk); #1;
      check_eq("lock_dst_dat", bus_main.dstDat_o[1], 64'(s40_out[c]));
      check_eq("lock_dst_src", 64'(bus_main.dstSrc_o[1]), 64'(s40_src[c]));
    end
    @(negedge clk);
    bus_main.srcVld_i = '0;
    @(posedge clk); #1;
    check_eq("lock_drain_vld", 64'(bus_main.dstVld_o), 64'h0);

    // Unlocked: re-arbitration each beat.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus_nl.srcTarget_i[0] = 1'b1; bus_nl.srcTarget_i[1] = 1'b1;
      bus_nl.srcVld_i[0] = 1'(s41_v0[c]); bus_nl.srcLast_i[0] = 1'(s41_l0[c]);
      bus_nl.srcDat_i[0] = 64'(s41_d0[c]);
      bus_nl.srcVld_i[1] = 1'(s41_v1[c]); bus_nl.srcLast_i[1] = 1'(s41_l1[c]);
      bus_nl.srcDat_i[1] = 64'(s41_d1[c]);
      #1;
      check_eq("nolock_src_rdy", 64'(bus_nl.srcRdy_o), 64'(s41_rdy[c]));
      @(posedge clk); #1;
      check_eq("nolock_dst_dat", bus_nl.dstDat_o[1], 64'(s41_out[c]));
      check_eq("nolock_dst_src", 64'(bus_nl.dstSrc_o[1]), 64'(s41_src[c]));
    end
    do_reset();

    // Backpressure: output held, no acceptance while full and not ready.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus_main.srcVld_i = 2'b01; bus_main.srcTarget_i = '0; bus_main.srcLast_i = 2'b01;
      bus_main.srcDat_i[0] = 64'(s42_d0[c]);
      bus_main.dstRdy_i[0] = 1'(s42_dr[c]);
      #1;
      check_eq("bp_src_rdy", 64'(bus_main.srcRdy_o), 64'(s42_rdy[c]));
      @(posedge clk); #1;
      check_eq("bp_dst_vld", 64'(bus_main.dstVld_o[0]), 64'h1);
      check_eq("bp_dst_dat", bus_main.dstDat_o[0], 64'(s42_out[c]));
    end
    do_reset();

    // Parallel destinations in one cycle.
    @(negedge clk);
    bus_main.srcVld_i = 2'b11; bus_main.srcLast_i = 2'b11;
    bus_main.srcTarget_i[0] = 1'b0; bus_main.srcTarget_i[1] = 1'b1;
    bus_main.srcDat_i[0] = 64'h55; bus_main.srcDat_i[1] = 64'h66;
    #1;
    check_eq("par_src_rdy", 64'(bus_main.srcRdy_o), 64'h3);
    @(posedge clk); #1;
    check_eq("par_dst_vld", 64'(bus_main.dstVld_o), 64'h3);
    check_eq("par_dst1_src", 64'(bus_main.dstSrc_o[1]), 64'h1);
    check_eq("par_dst1_dat", bus_main.dstDat_o[1], 64'h66);

    // Decode error on N=3 alongside a legal beat to dst2.
    @(negedge clk);
    bus_main.srcVld_i = '0;
    bus_n3.srcVld_i = 2'b11; bus_n3.srcLast_i = 2'b11;
    bus_n3.srcTarget_i[0] = 2'd3; bus_n3.srcTarget_i[1] = 2'd2;
    bus_n3.srcDat_i[0] = 64'h77; bus_n3.srcDat_i[1] = 64'h88;
    #1;
    check_eq("dec_src_rdy", 64'(bus_n3.srcRdy_o), 64'h3);
    check_eq("dec_err", 64'(bus_n3.srcDecErr_o), 64'h1);
    @(posedge clk); #1;
    check_eq("dec_dst_vld", 64'(bus_n3.dstVld_o), 64'h4);
    check_eq("dec_dst2_dat", bus_n3.dstDat_o[2], 64'h88);
    check_eq("dec_dst2_src", 64'(bus_n3.dstSrc_o[2]), 64'h1);
    @(negedge clk);
    bus_n3.srcVld_i = '0;
    #1;
    check_eq("dec_err_pulse", 64'(bus_n3.srcDecErr_o), 64'h0);
    @(posedge clk); #1;
    check_eq("dec_drain_vld", 64'(bus_n3.dstVld_o), 64'h0);
    do_reset();

    // Reset mid-burst abandons the lock.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus_main.srcVld_i = 2'b01; bus_main.srcTarget_i = '0; bus_main.srcLast_i = 2'b00;
      bus_main.srcDat_i[0] = 64'(40 + c);
      #1;
      check_eq("mid_src_rdy", 64'(bus_main.srcRdy_o), 64'h1);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    bus_main.srcDat_i[0] = 64'd42;
    #1;
    check_eq("mid_rst_rdy", 64'(bus_main.srcRdy_o), 64'h0);
    @(posedge clk); #1;
    check_eq("mid_rst_vld", 64'(bus_main.dstVld_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_main.srcVld_i = 2'b10; bus_main.srcLast_i = 2'b10;
    bus_main.srcDat_i[1] = 64'd50;
    #1;
    check_eq("post_rst_rdy", 64'(bus_main.srcRdy_o), 64'h2);
    @(posedge clk); #1;
    check_eq("post_rst_src", 64'(bus_main.dstSrc_o[0]), 64'h1);
    check_eq("post_rst_dat", bus_main.dstDat_o[0], 64'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
